// File: rtl/passcode_entry_ctrl_pkg.sv
// Shared types and constants for the passcode entry controller.
// Pure declarations: no latency, no flow control.
package passcode_pkg;

    localparam int DIGIT_W    = 2;
    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = DIGIT_W * NUM_DIGITS;
    localparam int PREV_W     = CODE_W - DIGIT_W;

    localparam logic [2:0] ANSWER_NONE = 3'd0;
    localparam logic [2:0] ANSWER_YES  = 3'd1;
    localparam logic [2:0] ANSWER_NO   = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_SHOW_YES,
        ST_SHOW_NO,
        ST_LOCKOUT
    } state_t;

    // Index of the set bit; only meaningful when the press vector is one-hot.
    function automatic logic [DIGIT_W-1:0] press_to_digit(input logic [NUM_DIGITS-1:0] press);
        logic [DIGIT_W-1:0] digit;
        digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (press[k]) digit = DIGIT_W'(k);
        end
        return digit;
    endfunction

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/passcode_entry_ctrl_if.sv
// Press inputs and display/status outputs of the passcode controller.
// master drives presses (keypad side), slave is the controller.
interface passcode_entry_ctrl_if;
    import passcode_pkg::*;

    logic [NUM_DIGITS-1:0] i_Press;
    logic [2:0]            o_Answer;
    logic [2:0]            o_Digit_Count;
    logic                  o_Unlocked;
    logic                  o_Locked_Out;

    modport master (
        output i_Press,
        input  o_Answer,
        input  o_Digit_Count,
        input  o_Unlocked,
        input  o_Locked_Out
    );

    modport slave (
        input  i_Press,
        output o_Answer,
        output o_Digit_Count,
        output o_Unlocked,
        output o_Locked_Out
    );

endinterface

// File: rtl/passcode_entry_ctrl_timer.sv
// Loadable down-counter; done is high in the cycle the count steps from 1 to 0.
// Load wins over counting; stops at zero, never wraps; no backpressure.
module passcode_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign done = en && !load && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/passcode_entry_ctrl.sv
// Collects 4 one-hot presses, compares with PASSCODE, shows Y/N for HOLD_CYCLES; 1-cycle latency, all outputs registered.
// Presses ignored while showing/locked out; PASSCODE_LOCKOUT_EN adds fail counting and a timed lockout.
module passcode_entry_ctrl
    import passcode_pkg::*;
#(
    parameter logic [CODE_W-1:0] PASSCODE       = 8'h1B,
    parameter int                HOLD_CYCLES    = 25000000,
    parameter int                TIMEOUT_CYCLES = 75000000,
    parameter int                LOCKOUT_CYCLES = 250000000,
    parameter int                MAX_FAILS      = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    passcode_entry_ctrl_if.slave  bus
);

    localparam int TIMER_W = timer_width(HOLD_CYCLES, TIMEOUT_CYCLES, LOCKOUT_CYCLES);

    state_t               state_q, state_d;
    logic [PREV_W-1:0]    digits_q, digits_d;
    logic [2:0]           count_q, count_d;
    logic [2:0]           answer_q, answer_d;
    logic                 unlocked_q, unlocked_d;
    logic                 locked_q, locked_d;

    logic                 press_vld;
    logic [DIGIT_W-1:0]   press_digit;
    logic [CODE_W-1:0]    entered_code;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_en;
    logic                 timer_done;

`ifdef PASSCODE_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    logic [FAIL_W-1:0]    fail_q, fail_d;
`endif

    // Multi-bit presses are treated as noise: no capture and no timer reload.
    assign press_vld    = $onehot(bus.i_Press);
    assign press_digit  = press_to_digit(bus.i_Press);
    assign entered_code = {digits_q, press_digit};
    assign timer_en     = (state_q != ST_IDLE);

    passcode_timer #(.WIDTH(TIMER_W)) u_timer (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        count_d    = count_q;
        timer_load = 1'b0;
        timer_val  = '0;
`ifdef PASSCODE_LOCKOUT_EN
        fail_d     = fail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_vld) begin
                    digits_d   = entered_code[PREV_W-1:0];
                    count_d    = 3'd1;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(TIMEOUT_CYCLES);
                    state_d    = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (press_vld) begin
                    digits_d   = entered_code[PREV_W-1:0];
                    count_d    = count_q + 3'd1;
                    timer_load = 1'b1;
                    if (count_q == 3'(NUM_DIGITS - 1)) begin
                        timer_val = TIMER_W'(HOLD_CYCLES);
                        if (entered_code == PASSCODE) begin
                            state_d = ST_SHOW_YES;
`ifdef PASSCODE_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end else begin
                            state_d = ST_SHOW_NO;
`ifdef PASSCODE_LOCKOUT_EN
                            if (fail_q != FAIL_W'(MAX_FAILS)) fail_d = fail_q + FAIL_W'(1);
`endif
                        end
                    end else begin
                        timer_val = TIMER_W'(TIMEOUT_CYCLES);
                    end
                end else if (timer_done) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW_YES: begin
                if (timer_done) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW_NO: begin
                if (timer_done) begin
                    count_d = '0;
                    state_d = ST_IDLE;
`ifdef PASSCODE_LOCKOUT_EN
                    if (fail_q == FAIL_W'(MAX_FAILS)) begin
                        timer_load = 1'b1;
                        timer_val  = TIMER_W'(LOCKOUT_CYCLES);
                        state_d    = ST_LOCKOUT;
                    end
`endif
                end
            end
`ifdef PASSCODE_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (timer_done) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_comb begin
        answer_d   = ANSWER_NONE;
        unlocked_d = 1'b0;
        locked_d   = 1'b0;
        case (state_d)
            ST_SHOW_YES: begin
                answer_d   = ANSWER_YES;
                unlocked_d = 1'b1;
            end
            ST_SHOW_NO: answer_d = ANSWER_NO;
            ST_LOCKOUT: begin
                answer_d = ANSWER_NO;
                locked_d = 1'b1;
            end
            default: answer_d = ANSWER_NONE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            count_q    <= '0;
            answer_q   <= ANSWER_NONE;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            answer_q   <= answer_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
        end
    end

`ifdef PASSCODE_LOCKOUT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Rst) fail_q <= '0;
        else       fail_q <= fail_d;
    end
    assign bus.o_Locked_Out = locked_q;
`else
    assign bus.o_Locked_Out = 1'b0;
`endif

    assign bus.o_Answer      = answer_q;
    assign bus.o_Digit_Count = count_q;
    assign bus.o_Unlocked    = unlocked_q;

endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// Directed bench for passcode_entry_ctrl with PASSCODE=1B, HOLD=4, TIMEOUT=10, LOCKOUT=8, MAX_FAILS=3.
module tb_passcode_entry_ctrl;
    import passcode_pkg::*;

    localparam int HOLD = 4;
    localparam int TMO  = 10;
    localparam int LOCK = 8;
    localparam int MAXF = 3;
    localparam logic [7:0] GOOD = 8'h1B;
    localparam logic [7:0] BAD  = 8'h1A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    passcode_entry_ctrl_if pif ();

    passcode_entry_ctrl #(
        .PASSCODE       (8'h1B),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .LOCKOUT_CYCLES (LOCK),
        .MAX_FAILS      (MAXF)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (pif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        pif.i_Press = 4'(1 << d);
        tick();
        pif.i_Press = '0;
    endtask

    task automatic enter(input logic [7:0] code);
        for (int i = 0; i < 4; i++) press(int'(code[7-2*i -: 2]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL reset_answer: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", pif.o_Digit_Count); end
        checks++; if (pif.o_Unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %0b expected 0", pif.o_Unlocked); end
        checks++; if (pif.o_Locked_Out !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", pif.o_Locked_Out); end
    endtask

    task automatic test_correct();
        press(0);
        checks++; if (pif.o_Digit_Count !== 3'd1) begin errors++; $display("FAIL correct_count1: got %0d expected 1", pif.o_Digit_Count); end
        press(1);
        press(2);
        checks++; if (pif.o_Digit_Count !== 3'd3) begin errors++; $display("FAIL correct_count3: got %0d expected 3", pif.o_Digit_Count); end
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL correct_early_answer: got %0d expected 0", pif.o_Answer); end
        press(3);
        checks++; if (pif.o_Answer !== 3'd1) begin errors++; $display("FAIL correct_answer: got %0d expected 1", pif.o_Answer); end
        checks++; if (pif.o_Unlocked !== 1'b1) begin errors++; $display("FAIL correct_unlocked: got %0b expected 1", pif.o_Unlocked); end
        checks++; if (pif.o_Digit_Count !== 3'd4) begin errors++; $display("FAIL correct_count4: got %0d expected 4", pif.o_Digit_Count); end
        for (int k = 2; k <= HOLD; k++) begin
            tick();
            checks++; if (pif.o_Answer !== 3'd1) begin errors++; $display("FAIL correct_hold cycle %0d: got %0d expected 1", k, pif.o_Answer); end
        end
        tick();
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL correct_release_answer: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Unlocked !== 1'b0) begin errors++; $display("FAIL correct_release_unlocked: got %0b expected 0", pif.o_Unlocked); end
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL correct_release_count: got %0d expected 0", pif.o_Digit_Count); end
    endtask

    task automatic test_wrong();
        enter(BAD);
        checks++; if (pif.o_Answer !== 3'd2) begin errors++; $display("FAIL wrong_answer: got %0d expected 2", pif.o_Answer); end
        checks++; if (pif.o_Unlocked !== 1'b0) begin errors++; $display("FAIL wrong_unlocked: got %0b expected 0", pif.o_Unlocked); end
        press(1);
        checks++; if (pif.o_Digit_Count !== 3'd4) begin errors++; $display("FAIL wrong_press_during_show: got %0d expected 4", pif.o_Digit_Count); end
        press(3);
        tick();
        checks++; if (pif.o_Answer !== 3'd2) begin errors++; $display("FAIL wrong_hold_last: got %0d expected 2", pif.o_Answer); end
        checks++; if (pif.o_Digit_Count !== 3'd4) begin errors++; $display("FAIL wrong_count_hold: got %0d expected 4", pif.o_Digit_Count); end
        tick();
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL wrong_release: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL wrong_release_count: got %0d expected 0", pif.o_Digit_Count); end
    endtask

    task automatic test_timeout();
        press(0);
        press(1);
        repeat (TMO - 1) tick();
        checks++; if (pif.o_Digit_Count !== 3'd2) begin errors++; $display("FAIL timeout_before: got %0d expected 2", pif.o_Digit_Count); end
        tick();
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", pif.o_Digit_Count); end
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL timeout_answer: got %0d expected 0", pif.o_Answer); end
        enter(GOOD);
        checks++; if (pif.o_Answer !== 3'd1) begin errors++; $display("FAIL timeout_then_good: got %0d expected 1", pif.o_Answer); end
        repeat (HOLD) tick();
        // A press on the timeout cycle itself must win.
        press(0);
        repeat (TMO - 1) tick();
        press(1);
        checks++; if (pif.o_Digit_Count !== 3'd2) begin errors++; $display("FAIL timeout_press_wins: got %0d expected 2", pif.o_Digit_Count); end
        repeat (TMO) tick();
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL timeout_second: got %0d expected 0", pif.o_Digit_Count); end
    endtask

    task automatic test_multi_bit();
        press(0);
        press(1);
        pif.i_Press = 4'b0011;
        tick();
        pif.i_Press = '0;
        checks++; if (pif.o_Digit_Count !== 3'd2) begin errors++; $display("FAIL multi_ignored: got %0d expected 2", pif.o_Digit_Count); end
        press(2);
        press(3);
        checks++; if (pif.o_Answer !== 3'd1) begin errors++; $display("FAIL multi_then_good: got %0d expected 1", pif.o_Answer); end
        repeat (HOLD) tick();
        // Multi-bit press must not reload the timeout.
        press(2);
        repeat (4) tick();
        pif.i_Press = 4'b0110;
        tick();
        pif.i_Press = '0;
        repeat (4) tick();
        checks++; if (pif.o_Digit_Count !== 3'd1) begin errors++; $display("FAIL multi_before_timeout: got %0d expected 1", pif.o_Digit_Count); end
        tick();
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL multi_no_restart: got %0d expected 0", pif.o_Digit_Count); end
    endtask

    task automatic test_lockout();
        logic exp_lk;
        do_reset();
        enter(BAD);
        repeat (HOLD) tick();
        enter(BAD);
        repeat (HOLD) tick();
        enter(BAD);
        checks++; if (pif.o_Answer !== 3'd2) begin errors++; $display("FAIL lockout_third_answer: got %0d expected 2", pif.o_Answer); end
`ifdef PASSCODE_LOCKOUT_EN
        for (int k = 1; k < HOLD + LOCK; k++) begin
            press(k % 4);
            exp_lk = (k >= HOLD);
            checks++; if (pif.o_Answer !== 3'd2) begin errors++; $display("FAIL lockout_answer cycle %0d: got %0d expected 2", k, pif.o_Answer); end
            checks++; if (pif.o_Locked_Out !== exp_lk) begin errors++; $display("FAIL lockout_flag cycle %0d: got %0b expected %0b", k, pif.o_Locked_Out, exp_lk); end
        end
        tick();
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL lockout_release_answer: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Locked_Out !== 1'b0) begin errors++; $display("FAIL lockout_release_flag: got %0b expected 0", pif.o_Locked_Out); end
`else
        exp_lk = 1'b0;
        for (int k = 1; k < HOLD; k++) begin
            tick();
            checks++; if (pif.o_Locked_Out !== exp_lk) begin errors++; $display("FAIL nolock_flag cycle %0d: got %0b expected 0", k, pif.o_Locked_Out); end
        end
        tick();
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL nolock_release: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Locked_Out !== 1'b0) begin errors++; $display("FAIL nolock_flag_after: got %0b expected 0", pif.o_Locked_Out); end
`endif
        enter(GOOD);
        checks++; if (pif.o_Unlocked !== 1'b1) begin errors++; $display("FAIL lockout_then_good: got %0b expected 1", pif.o_Unlocked); end
        repeat (HOLD) tick();
    endtask

    task automatic test_reset_mid();
        press(0);
        press(1);
        press(2);
        checks++; if (pif.o_Digit_Count !== 3'd3) begin errors++; $display("FAIL rstmid_before: got %0d expected 3", pif.o_Digit_Count); end
        do_reset();
        checks++; if (pif.o_Digit_Count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", pif.o_Digit_Count); end
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL rstmid_answer: got %0d expected 0", pif.o_Answer); end
        enter(GOOD);
        do_reset();
        checks++; if (pif.o_Unlocked !== 1'b0) begin errors++; $display("FAIL rstshow_unlocked: got %0b expected 0", pif.o_Unlocked); end
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL rstshow_answer: got %0d expected 0", pif.o_Answer); end
        // Wrong, correct, wrong, wrong: the correct code clears the fail count.
        enter(BAD);
        repeat (HOLD) tick();
        enter(GOOD);
        repeat (HOLD) tick();
        enter(BAD);
        repeat (HOLD) tick();
        enter(BAD);
        repeat (HOLD) tick();
        checks++; if (pif.o_Answer !== 3'd0) begin errors++; $display("FAIL wcww_answer: got %0d expected 0", pif.o_Answer); end
        checks++; if (pif.o_Locked_Out !== 1'b0) begin errors++; $display("FAIL wcww_locked: got %0b expected 0", pif.o_Locked_Out); end
    endtask

    initial begin
        pif.i_Press = '0;
        test_reset();
        test_correct();
        test_wrong();
        test_timeout();
        test_multi_bit();
        test_lockout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
